// File: rtl/code_display_pkg.sv
// code_display_pkg: shared types and constants for the code_display block.
//   state_t      : conversion FSM states (IDLE, SHIFT, DONE)
//   DIGITS       : number of display digits
//   BIN_BITS     : width of the binary shift-in register (covers 0..9999)
//   MAX_VALUE    : largest value shown; anything above shows dashes
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : only segment g lit (active-low)
//   bcd_adjust() : double-dabble "add 3 to every nibble >= 5" step
package code_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGITS    = 4;
  localparam int BIN_BITS  = 14;
  localparam int MAX_VALUE = 9999;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/code_display_if.sv
// code_display_if: board-facing signal bundle of the code_display block.
//   code      : 32-bit value to display (driven by the CPU data memory)
//   an        : active-low digit enables, an[0] = least significant digit
//   seg       : active-low cathodes, seg[6:0] = gfedcba, seg[7] = dp (always 1)
//   value_bcd : committed BCD value, 16'hFFFF = overflow
//   busy      : conversion in progress
//   state     : debug view of the conversion FSM
// Handshake: there is no valid/ready pair. code is a level that is compared
// against the last captured value whenever the FSM is idle; any difference
// starts a conversion, and changes while busy are picked up afterwards.
interface code_display_if;
  import code_display_pkg::*;

  logic [31:0] code;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [15:0] value_bcd;
  logic        busy;
  state_t      state;

  modport master (
    output code,
    input  an, seg, value_bcd, busy, state
  );

  modport slave (
    input  code,
    output an, seg, value_bcd, busy, state
  );

endinterface

// File: rtl/code_display_seg7_decode.sv
// seg7_decode: combinational nibble to active-low seven-segment pattern.
//   nibble : BCD digit 0..9, or F for the overflow dash
//   blank  : force all segments off
//   seg    : {dp, g, f, e, d, c, b, a}, active-low, dp always off
// Nibbles A..E never occur in committed values and are shown blank.
module seg7_decode
  import code_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0:    seg = 8'hC0;
        4'h1:    seg = 8'hF9;
        4'h2:    seg = 8'hA4;
        4'h3:    seg = 8'hB0;
        4'h4:    seg = 8'h99;
        4'h5:    seg = 8'h92;
        4'h6:    seg = 8'h82;
        4'h7:    seg = 8'hF8;
        4'h8:    seg = 8'h80;
        4'h9:    seg = 8'h90;
        4'hF:    seg = SEG_DASH;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/code_display.sv
// code_display: converts the 32-bit code word to four BCD digits with a
// sequential double-dabble engine and drives a multiplexed, active-low,
// 4-digit seven-segment display.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : code_display_if.slave (code in; an, seg, value_bcd, busy, state out)
// Parameter SCAN_DIV (>= 2): clocks per digit slot.
// Build option: define CODE_DISPLAY_LZB_EN for leading-zero blanking of
// digits 3..1 (digit 0 and overflow dashes are never blanked).
module code_display
  import code_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic           clk,
  input  logic           reset,
  code_display_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  // Conversion engine state
  state_t                state_q;
  logic [31:0]           captured;
  logic [BIN_BITS-1:0]   bin;
  logic [15:0]           bcd;
  logic [3:0]            iter;
  logic [15:0]           value_bcd_q;
  logic                  busy_q;
  logic [15:0]           bcd_adj;

  assign bcd_adj = bcd_adjust(bcd);

  // Only captured[13:0] is shifted; values above MAX_VALUE are replaced by
  // dashes at commit using the full 32-bit compare, so truncation is harmless.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      captured    <= '0;
      bin         <= '0;
      bcd         <= '0;
      iter        <= '0;
      value_bcd_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.code != captured) begin
            captured <= bus.code;
            bin      <= bus.code[BIN_BITS-1:0];
            bcd      <= '0;
            iter     <= '0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd  <= {bcd_adj[14:0], bin[BIN_BITS-1]};
          bin  <= {bin[BIN_BITS-2:0], 1'b0};
          iter <= iter + 4'd1;
          if (iter == 4'(BIN_BITS - 1)) state_q <= DONE;
        end
        DONE: begin
          value_bcd_q <= (captured > 32'(MAX_VALUE)) ? 16'hFFFF : bcd;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Display scan
  logic [DIV_W-1:0] div_q;
  logic [1:0]       idx_q;
  logic [3:0]       an_q;
  logic [7:0]       seg_q;
  logic [3:0]       nibble;
  logic             blank;
  logic [7:0]       seg_next;

  assign nibble = value_bcd_q[{idx_q, 2'b00} +: 4];

`ifdef CODE_DISPLAY_LZB_EN
  // A digit is blanked when it and every more significant digit are zero.
  // FFFF is nonzero, so dashes are never blanked.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd1:    blank = (value_bcd_q[15:4]  == 12'h000);
      2'd2:    blank = (value_bcd_q[15:8]  == 8'h00);
      2'd3:    blank = (value_bcd_q[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  seg7_decode u_seg7_decode (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg_next)
  );

  // an/seg are registered from the current index, so they lag it by a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      if (div_q == DIV_W'(SCAN_DIV - 1)) begin
        div_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= seg_next;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.value_bcd = value_bcd_q;
  assign bus.busy      = busy_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_code_display.sv
// tb_code_display: directed bench for code_display with SCAN_DIV = 4.
// Each scenario task drives code/reset and checks the outputs inline.
module tb_code_display;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  code_display_if bus();

  code_display #(.SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CODE_DISPLAY_LZB_EN
  localparam logic [7:0] LEAD_ZERO_SEG = 8'hFF;
`else
  localparam logic [7:0] LEAD_ZERO_SEG = 8'hC0;
`endif

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Advance until busy is low; edges counts the rising edges taken.
  task automatic wait_commit(output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      edges++;
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Advance to the first cycle of a digit-0 slot.
  task automatic sync_slot0(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = bus.an;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (prev !== 4'b1110 && bus.an === 4'b1110) begin
        ok = 1'b1;
        return;
      end
      prev = bus.an;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.code = 32'd1;
    repeat (3) tick();
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL reset_an: got %b expected 1111", bus.an); end
    checks++; if (bus.seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected ff", bus.seg); end
    checks++; if (bus.value_bcd !== 16'h0000) begin errors++; $display("FAIL reset_value: got %h expected 0000", bus.value_bcd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b1;
    for (int e = 0; e < 16; e++) begin
      tick();
      if (e == 0) begin
        checks++; if (bus.an !== 4'b1110) begin errors++; $display("FAIL first_an: got %b expected 1110", bus.an); end
        checks++; if (bus.seg !== 8'hC0) begin errors++; $display("FAIL first_seg: got %h expected c0", bus.seg); end
      end
      if (e < 15) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL latency_busy e%0d: got %b expected 1", e, bus.busy); end
        checks++; if (bus.value_bcd !== 16'h0000) begin errors++; $display("FAIL latency_value e%0d: got %h expected 0000", e, bus.value_bcd); end
      end else begin
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL commit_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.value_bcd !== 16'h0001) begin errors++; $display("FAIL commit_value: got %h expected 0001", bus.value_bcd); end
      end
    end
  endtask

  task automatic test_scan_1234;
    int edges;
    bit ok;
    logic [3:0] exp_an [4];
    logic [7:0] exp_seg [4];
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    bus.code = 32'd1234;
    wait_commit(edges, ok);
    checks++; if (!ok || edges != 16) begin errors++; $display("FAIL scan_latency: got %0d edges expected 16", edges); end
    checks++; if (bus.value_bcd !== 16'h1234) begin errors++; $display("FAIL scan_value: got %h expected 1234", bus.value_bcd); end
    sync_slot0(ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan_sync: got no slot0 expected slot0"); end
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < 4; s++)
        for (int c = 0; c < 4; c++) begin
          checks++; if (bus.an !== exp_an[s]) begin errors++; $display("FAIL scan_an s%0d c%0d: got %b expected %b", s, c, bus.an, exp_an[s]); end
          checks++; if (bus.seg !== exp_seg[s]) begin errors++; $display("FAIL scan_seg s%0d c%0d: got %h expected %h", s, c, bus.seg, exp_seg[s]); end
          tick();
        end
  endtask

  task automatic test_overflow;
    int edges;
    bit ok;
    logic [31:0] vals [3];
    logic [15:0] exp_val [3];
    logic [7:0]  exp_seg [3];
    vals    = '{32'd10000, 32'hFFFF_FFFF, 32'd9999};
    exp_val = '{16'hFFFF, 16'hFFFF, 16'h9999};
    exp_seg = '{8'hBF, 8'hBF, 8'h90};
    for (int v = 0; v < 3; v++) begin
      bus.code = vals[v];
      wait_commit(edges, ok);
      checks++; if (!ok || edges != 16) begin errors++; $display("FAIL ovf_latency v%0d: got %0d edges expected 16", v, edges); end
      checks++; if (bus.value_bcd !== exp_val[v]) begin errors++; $display("FAIL ovf_value v%0d: got %h expected %h", v, bus.value_bcd, exp_val[v]); end
      sync_slot0(ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_sync v%0d: got no slot0 expected slot0", v); end
      for (int s = 0; s < 4; s++) begin
        checks++; if (bus.seg !== exp_seg[v]) begin errors++; $display("FAIL ovf_seg v%0d s%0d: got %h expected %h", v, s, bus.seg, exp_seg[v]); end
        repeat (4) tick();
      end
    end
  endtask

  task automatic test_change_mid;
    logic [15:0] exp_val;
    logic        exp_busy;
    bus.code = 32'd12;
    for (int e = 0; e < 32; e++) begin
      tick();
      if (e == 5) bus.code = 32'd20;
      exp_val  = (e < 15) ? 16'h9999 : ((e < 31) ? 16'h0012 : 16'h0020);
      exp_busy = (e != 15 && e != 31);
      checks++; if (bus.value_bcd !== exp_val) begin errors++; $display("FAIL mid_value e%0d: got %h expected %h", e, bus.value_bcd, exp_val); end
      checks++; if (bus.busy !== exp_busy) begin errors++; $display("FAIL mid_busy e%0d: got %b expected %b", e, bus.busy, exp_busy); end
    end
  endtask

  task automatic test_lzb;
    int edges;
    bit ok;
    logic [31:0] vals [2];
    logic [15:0] exp_val [2];
    logic [7:0]  exp_seg0 [2];
    vals     = '{32'd7, 32'd0};
    exp_val  = '{16'h0007, 16'h0000};
    exp_seg0 = '{8'hF8, 8'hC0};
    for (int v = 0; v < 2; v++) begin
      bus.code = vals[v];
      wait_commit(edges, ok);
      checks++; if (!ok || edges != 16) begin errors++; $display("FAIL lzb_latency v%0d: got %0d edges expected 16", v, edges); end
      checks++; if (bus.value_bcd !== exp_val[v]) begin errors++; $display("FAIL lzb_value v%0d: got %h expected %h", v, bus.value_bcd, exp_val[v]); end
      sync_slot0(ok);
      checks++; if (!ok) begin errors++; $display("FAIL lzb_sync v%0d: got no slot0 expected slot0", v); end
      checks++; if (bus.seg !== exp_seg0[v]) begin errors++; $display("FAIL lzb_seg0 v%0d: got %h expected %h", v, bus.seg, exp_seg0[v]); end
      repeat (4) tick();
      for (int s = 1; s < 4; s++) begin
        checks++; if (bus.seg !== LEAD_ZERO_SEG) begin errors++; $display("FAIL lzb_seg v%0d s%0d: got %h expected %h", v, s, bus.seg, LEAD_ZERO_SEG); end
        repeat (4) tick();
      end
    end
  endtask

  task automatic test_async_reset;
    int edges;
    bit ok;
    bus.code = 32'd8;
    wait_commit(edges, ok);
    checks++; if (bus.value_bcd !== 16'h0008) begin errors++; $display("FAIL ar_pre_value: got %h expected 0008", bus.value_bcd); end
    bus.code = 32'd55;
    tick();
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ar_busy: got %b expected 1", bus.busy); end
    repeat (7) tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.an !== 4'b1111) begin errors++; $display("FAIL ar_an: got %b expected 1111", bus.an); end
    checks++; if (bus.seg !== 8'hFF) begin errors++; $display("FAIL ar_seg: got %h expected ff", bus.seg); end
    checks++; if (bus.value_bcd !== 16'h0000) begin errors++; $display("FAIL ar_value: got %h expected 0000", bus.value_bcd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ar_busy_low: got %b expected 0", bus.busy); end
    tick();
    reset = 1'b1;
    wait_commit(edges, ok);
    checks++; if (!ok || edges != 16) begin errors++; $display("FAIL ar_latency: got %0d edges expected 16", edges); end
    checks++; if (bus.value_bcd !== 16'h0055) begin errors++; $display("FAIL ar_value_after: got %h expected 0055", bus.value_bcd); end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b0;
    bus.code = 32'd0;
    test_reset();
    test_scan_1234();
    test_overflow();
    test_change_mid();
    test_lzb();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
